fetch_unit: RTL

Instruction-fetch and cycle-timing stage of the 4004 core, sitting directly upstream of Control_Unit. It sequences the 8-phase instruction cycle (A1 A2 A3 M1 M2 X1 X2 X3) and maintains the 12-bit program counter. It drives PC nibbles onto the 4-bit bus during A1–A3, assembles the 8-bit opcode from M1/M2 bus reads, and presents it to Control_Unit's `instruction` input together with a one-cycle valid strobe.

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/program_counter.sv | 48 ++++
 rtl/fetch_unit.sv | 101 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage and its consumers.
// Provides the 8-phase instruction-cycle encoding (A1..X3) and the datapath
// widths used by fetch_unit, program_counter and Control_Unit.
package fetch_pkg;

    localparam int unsigned PC_W     = 12;
    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned PHASE_W  = 3;
    localparam int unsigned INSTR_W  = 2 * NIBBLE_W;

    typedef enum logic [PHASE_W-1:0] {
        A1 = 3'd0,
        A2 = 3'd1,
        A3 = 3'd2,
        M1 = 3'd3,
        M2 = 3'd4,
        X1 = 3'd5,
        X2 = 3'd6,
        X3 = 3'd7
    } phase_e;

    // Successor phase; X3 wraps back to A1 through the natural 3-bit overflow.
    function automatic phase_e next_phase(input phase_e p);
        logic [PHASE_W-1:0] n;
        n = p + PHASE_W'(1);
        return phase_e'(n);
    endfunction

endpackage

// File: rtl/program_counter.sv
// 12-bit program counter with stall, increment and load.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset (loads RESET_PC)
//   hold         freezes the counter; overrides load and inc
//   inc          advance by one, modulo 2^PC_W
//   load         replace with load_value; has priority over inc
//   load_value   load target
//   pc           current counter value
module program_counter
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 12'h000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hold,
    input  logic            inc,
    input  logic            load,
    input  logic [PC_W-1:0] load_value,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // Next-value select: hold > load > inc > keep.
    always_comb begin
        pc_d = pc_q;
        if (!hold) begin
            if (load) begin
                pc_d = load_value;
            end else if (inc) begin
                pc_d = pc_q + PC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch and cycle-timing stage of the 4004 core.
// Sequences the A1..X3 phases, drives PC nibbles onto the bus in A1-A3,
// assembles {OPR, OPA} from the M1/M2 bus reads and strobes it in X1.
// Ports:
//   clk_2, reset          clock and asynchronous active-low reset
//   data_in               ROM nibble (OPR in M1, OPA in M2)
//   hold                  stall; freezes every register
//   jump_load, jump_addr  branch target, taken only when leaving X3
//   data_out, data_out_en address nibble and bus drive enable
//   sync                  high in X3
//   instruction           assembled opcode, instruction_valid strobes in X1
//   cycle_state, pc       current phase and program counter
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 12'h000
) (
    input  logic                clk_2,
    input  logic                reset,
    input  logic [NIBBLE_W-1:0] data_in,
    input  logic                hold,
    input  logic                jump_load,
    input  logic [PC_W-1:0]     jump_addr,
    output logic [NIBBLE_W-1:0] data_out,
    output logic                data_out_en,
    output logic                sync,
    output logic [INSTR_W-1:0]  instruction,
    output logic                instruction_valid,
    output logic [PHASE_W-1:0]  cycle_state,
    output logic [PC_W-1:0]     pc
);

    phase_e               state_q, state_d;
    logic [NIBBLE_W-1:0]  opr_q, opr_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic                 pc_inc;
    logic                 pc_load;

    // Phase sequencing and fetch datapath updates; everything freezes under hold.
    always_comb begin
        state_d = state_q;
        opr_d   = opr_q;
        instr_d = instr_q;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        if (!hold) begin
            state_d = next_phase(state_q);
            case (state_q)
                M1: opr_d = data_in;
                M2: begin
                    instr_d = {opr_q, data_in};
                    pc_inc  = 1'b1;
                end
                X3: pc_load = jump_load;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            state_q <= A1;
            opr_q   <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            opr_q   <= opr_d;
            instr_q <= instr_d;
        end
    end

    program_counter #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk_2),
        .rst_n      (reset),
        .hold       (hold),
        .inc        (pc_inc),
        .load       (pc_load),
        .load_value (jump_addr),
        .pc         (pc)
    );

    // Bus address nibble, low nibble first.
    always_comb begin
        data_out = '0;
        case (state_q)
            A1: data_out = pc[3:0];
            A2: data_out = pc[7:4];
            A3: data_out = pc[11:8];
            default: ;
        endcase
    end

    assign data_out_en       = (state_q == A1) || (state_q == A2) || (state_q == A3);
    assign sync              = (state_q == X3) && !hold;
    assign instruction_valid = (state_q == X1) && !hold;
    assign instruction       = instr_q;
    assign cycle_state       = state_q;

endmodule
